// File: rtl/sys_defs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sys_defs : shared bus encodings and icache controller types       |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package sys_defs;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam int LINE_OFFSET_W = 3;
    localparam int LINE_ADDR_W   = 64 - LINE_OFFSET_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ictrl_state_t;

    typedef struct packed {
        logic                   valid;
        logic [3:0]             tag;
        logic [LINE_ADDR_W-1:0] line_addr;
    } mshr_entry_t;
endpackage
`default_nettype wire

// File: rtl/icache_mshr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_mshr : outstanding line-load table (lookup/alloc/free)     |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
module icache_mshr
    import sys_defs::*;
#(
    parameter int NUM_MSHR = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LINE_ADDR_W-1:0] i_lookup_if,
    input  logic [LINE_ADDR_W-1:0] i_lookup_pf,
    output logic                   o_hit_if,
    output logic                   o_hit_pf,
    input  logic                   i_alloc,
    input  logic [3:0]             i_alloc_tag,
    input  logic [LINE_ADDR_W-1:0] i_alloc_addr,
    input  logic [3:0]             i_free_tag,
    output logic                   o_free_hit,
    output logic [LINE_ADDR_W-1:0] o_free_addr,
    output logic                   o_full
);
    localparam int IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

    mshr_entry_t      r_tbl [NUM_MSHR];
    logic [IDX_W-1:0] w_alloc_idx;
    logic [IDX_W-1:0] w_free_idx;

    // Descending scan so the lowest-numbered matching/free slot wins.
    always_comb begin
        o_hit_if    = 1'b0;
        o_hit_pf    = 1'b0;
        o_full      = 1'b1;
        o_free_hit  = 1'b0;
        o_free_addr = '0;
        w_alloc_idx = '0;
        w_free_idx  = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (r_tbl[i].valid && r_tbl[i].line_addr == i_lookup_if) o_hit_if = 1'b1;
            if (r_tbl[i].valid && r_tbl[i].line_addr == i_lookup_pf) o_hit_pf = 1'b1;
            if (!r_tbl[i].valid) begin
                o_full      = 1'b0;
                w_alloc_idx = IDX_W'(i);
            end
            if (r_tbl[i].valid && i_free_tag != 4'd0 && r_tbl[i].tag == i_free_tag) begin
                o_free_hit  = 1'b1;
                o_free_addr = r_tbl[i].line_addr;
                w_free_idx  = IDX_W'(i);
            end
        end
    end

    // Allocation uses the pre-free view, so a freed slot is reused a cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MSHR; i++) r_tbl[i] <= '0;
        end else begin
            if (o_free_hit) r_tbl[w_free_idx].valid <= 1'b0;
            if (i_alloc && !o_full)
                r_tbl[w_alloc_idx] <= '{valid: 1'b1, tag: i_alloc_tag, line_addr: i_alloc_addr};
        end
    end
endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_ctrl : icache miss/refill controller with next-line prefetch|
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
module icache_ctrl
    import sys_defs::*;
#(
    parameter int NUM_MSHR       = 4,
    parameter int PREFETCH_LINES = 2,
    parameter int ADDR_W         = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_req,
    output logic [63:0]       if_data,
    output logic              if_valid,
    output logic [ADDR_W-1:0] cache_rd_pc,
    input  logic [63:0]       cache_rd_data,
    input  logic              cache_rd_valid,
    output logic              cache_wr_en,
    output logic [ADDR_W-1:0] cache_wr_pc,
    output logic [63:0]       cache_wr_data,
    input  logic              mem_grant,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    input  logic [3:0]        mem2proc_response,
    input  logic [3:0]        mem2proc_tag,
    input  logic [63:0]       mem2proc_data
);
    localparam int CNT_W = 4;

    ictrl_state_t           r_state;
    logic [LINE_ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_pc;
    logic [63:0]            r_wr_data;

    logic [LINE_ADDR_W-1:0] w_if_line;
    logic [LINE_ADDR_W-1:0] w_issue_line;
    logic [LINE_ADDR_W-1:0] w_free_line;
    logic w_if_in_tbl, w_issue_in_tbl, w_full, w_free_hit;
    logic w_miss, w_prefetch, w_skip, w_issuing, w_accept, w_new_miss, w_step, w_last;

    assign w_if_line    = if_pc[ADDR_W-1:LINE_OFFSET_W];
    assign w_issue_line = r_base + LINE_ADDR_W'(r_cnt);
    assign w_miss       = if_req & ~cache_rd_valid;
    assign w_prefetch   = (r_cnt != '0);
    assign w_skip       = w_prefetch & w_issue_in_tbl;
    assign w_issuing    = (r_state == ISSUE) & ~w_full & ~w_skip;
    assign w_accept     = w_issuing & mem_grant & (mem2proc_response != 4'd0);
    assign w_step       = w_accept | ((r_state == ISSUE) & w_skip);
    assign w_last       = (r_cnt == CNT_W'(PREFETCH_LINES));
    assign w_new_miss   = w_miss & ~w_if_in_tbl & (w_if_line != r_base) & (w_if_line != w_issue_line);

    assign cache_rd_pc      = if_pc;
    assign if_data          = cache_rd_data;
    assign if_valid         = if_req & cache_rd_valid & ~reset;
    assign proc2mem_command = w_issuing ? BUS_LOAD : BUS_NONE;
    assign proc2mem_addr    = w_issuing ? {w_issue_line, {LINE_OFFSET_W{1'b0}}} : '0;
    assign cache_wr_en      = r_wr_en;
    assign cache_wr_pc      = r_wr_pc;
    assign cache_wr_data    = r_wr_data;

    icache_mshr #(.NUM_MSHR(NUM_MSHR)) u_mshr (
        .clock        (clock),
        .reset        (reset),
        .i_lookup_if  (w_if_line),
        .i_lookup_pf  (w_issue_line),
        .o_hit_if     (w_if_in_tbl),
        .o_hit_pf     (w_issue_in_tbl),
        .i_alloc      (w_accept),
        .i_alloc_tag  (mem2proc_response),
        .i_alloc_addr (w_issue_line),
        .i_free_tag   (mem2proc_tag),
        .o_free_hit   (w_free_hit),
        .o_free_addr  (w_free_line),
        .o_full       (w_full)
    );

    // Prefetches yield to a fresh miss or a full table; the demand load never does.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss && !w_if_in_tbl) begin
                        r_base  <= w_if_line;
                        r_cnt   <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_step) r_cnt <= r_cnt + 1'b1;
                    if (w_prefetch && (w_new_miss || w_full)) r_state <= IDLE;
                    else if (w_step && w_last)                r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_pc   <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_free_hit;
            r_wr_pc   <= {w_free_line, {LINE_OFFSET_W{1'b0}}};
            r_wr_data <= mem2proc_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// tb_icache_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_icache_ctrl;
    localparam int NUM_MSHR       = 4;
    localparam int PREFETCH_LINES = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] if_pc;
    logic        if_req;
    logic [63:0] if_data;
    logic        if_valid;
    logic [63:0] cache_rd_pc;
    logic [63:0] cache_rd_data;
    logic        cache_rd_valid;
    logic        cache_wr_en;
    logic [63:0] cache_wr_pc;
    logic [63:0] cache_wr_data;
    logic        mem_grant;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    icache_ctrl #(.NUM_MSHR(NUM_MSHR), .PREFETCH_LINES(PREFETCH_LINES), .ADDR_W(64)) dut (
        .clock(clock), .reset(reset), .if_pc(if_pc), .if_req(if_req), .if_data(if_data),
        .if_valid(if_valid), .cache_rd_pc(cache_rd_pc), .cache_rd_data(cache_rd_data),
        .cache_rd_valid(cache_rd_valid), .cache_wr_en(cache_wr_en), .cache_wr_pc(cache_wr_pc),
        .cache_wr_data(cache_wr_data), .mem_grant(mem_grant), .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr), .mem2proc_response(mem2proc_response),
        .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data)
    );

    // Reference model: outstanding loads as a list, pending requests as a to-do list of lines.
    typedef struct { logic [3:0] tag; logic [60:0] line; } ent_t;
    ent_t        m_tbl[$];
    logic [60:0] m_plan[$];
    int          m_issued;
    logic [60:0] m_base;
    bit          m_wr_pend;
    logic [60:0] m_wr_line;
    logic [63:0] m_wr_data;
    bit          m_issuing, m_skip;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_wr_pc, e_wr_data;
    bit          e_ifv, e_wr_en;

    function automatic bit line_in_tbl(logic [60:0] l);
        foreach (m_tbl[i]) if (m_tbl[i].line == l) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit tag_in_tbl(logic [3:0] t);
        foreach (m_tbl[i]) if (m_tbl[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_eval();
        bit full = (m_tbl.size() >= NUM_MSHR);
        m_issuing = 1'b0;
        m_skip    = 1'b0;
        if (m_plan.size() != 0) begin
            m_skip    = (m_issued != 0) && line_in_tbl(m_plan[0]);
            m_issuing = !full && !m_skip;
        end
        e_cmd     = m_issuing ? 2'd1 : 2'd0;
        e_addr    = m_issuing ? {m_plan[0], 3'b000} : 64'd0;
        e_ifv     = if_req & cache_rd_valid & ~reset;
        e_wr_en   = m_wr_pend;
        e_wr_pc   = {m_wr_line, 3'b000};
        e_wr_data = m_wr_data;
    endtask

    task automatic model_update();
        bit          full, miss, was_idle, hit_if, pf, newmiss, accept;
        logic [60:0] ifline, head;
        if (reset) begin
            m_tbl.delete(); m_plan.delete();
            m_issued = 0; m_base = '0; m_wr_pend = 1'b0;
            return;
        end
        full     = (m_tbl.size() >= NUM_MSHR);
        ifline   = if_pc[63:3];
        miss     = if_req && !cache_rd_valid;
        was_idle = (m_plan.size() == 0);
        hit_if   = line_in_tbl(ifline);
        head     = was_idle ? 61'd0 : m_plan[0];
        pf       = (m_issued != 0);
        newmiss  = miss && !hit_if && ifline != m_base && ifline != head;
        accept   = m_issuing && mem_grant && mem2proc_response != 4'd0;
        m_wr_pend = 1'b0;
        if (mem2proc_tag != 4'd0) begin
            for (int i = 0; i < m_tbl.size(); i++) begin
                if (m_tbl[i].tag == mem2proc_tag) begin
                    m_wr_pend = 1'b1; m_wr_line = m_tbl[i].line; m_wr_data = mem2proc_data;
                    m_tbl.delete(i);
                    break;
                end
            end
        end
        if (accept) m_tbl.push_back('{tag: mem2proc_response, line: head});
        if (accept || m_skip) begin void'(m_plan.pop_front()); m_issued++; end
        if (!was_idle && pf && (newmiss || full)) m_plan.delete();
        if (was_idle && miss && !hit_if) begin
            m_base = ifline; m_issued = 0;
            for (int k = 0; k <= PREFETCH_LINES; k++) m_plan.push_back(ifline + 61'(k));
        end
    endtask

    task automatic set_in(bit req, logic [63:0] pc, bit rdv, bit gnt, logic [3:0] resp,
                          logic [3:0] tg, logic [63:0] dat);
        if_req = req; if_pc = pc; cache_rd_valid = rdv; mem_grant = gnt;
        mem2proc_response = resp; mem2proc_tag = tg; mem2proc_data = dat;
    endtask

    task automatic sample(); model_eval(); @(negedge clock); endtask
    task automatic next();   model_update(); @(posedge clock); #1; endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 64'd0, 0, 0, 0, 0, 64'd0);
        cache_rd_data = 64'd0;
        repeat (2) begin sample(); next(); end
        reset = 1'b0;
    endtask

    task automatic burst(logic [63:0] pc, logic [3:0] t0, logic [3:0] t1, logic [3:0] t2);
        logic [3:0] t [3];
        t[0] = t0; t[1] = t1; t[2] = t2;
        set_in(1, pc, 0, 1, 0, 0, 64'd0); sample(); next();
        for (int i = 0; i < 3; i++) begin set_in(0, 64'd0, 0, 1, t[i], 0, 64'd0); sample(); next(); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 64'd0, 0, 0, 0, 0, 64'd0);
        cache_rd_data = 64'h1234_5678_9abc_def0;
        sample(); next();
        sample();
        total++;
        if (proc2mem_command !== 2'd0 || proc2mem_addr !== 64'd0 || cache_wr_en !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cmd=%0d addr=%h wr_en=%b if_valid=%b want 0/0/0/0",
                     proc2mem_command, proc2mem_addr, cache_wr_en, if_valid);
        end
        next();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 64'h100, 1, 1, 0, 0, 64'd0);
            sample();
            total++;
            if (if_valid !== 1'b1 || if_data !== 64'h1234_5678_9abc_def0 || cache_rd_pc !== 64'h100
                || proc2mem_command !== 2'd0) begin
                bad++;
                $display("FAIL hit[%0d]: valid=%b data=%h rd_pc=%h cmd=%0d want 1/123456789abcdef0/100/0",
                         i, if_valid, if_data, cache_rd_pc, proc2mem_command);
            end
            next();
        end
    endtask

    task automatic test_prefetch_burst();
        logic [1:0]  ec [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        logic [63:0] ea [5] = '{64'h0, 64'h100, 64'h108, 64'h110, 64'h0};
        logic [3:0]  rs [5] = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(i == 0, 64'h100, 0, 1, rs[i], 0, 64'd0);
            sample();
            total++;
            if (proc2mem_command !== ec[i] || proc2mem_addr !== ea[i]) begin
                bad++;
                $display("FAIL burst[%0d]: cmd=%0d addr=%h want cmd=%0d addr=%h",
                         i, proc2mem_command, proc2mem_addr, ec[i], ea[i]);
            end
            next();
        end
        set_in(0, 64'd0, 0, 0, 0, 4'd3, 64'h33); sample(); next();
        set_in(0, 64'd0, 0, 0, 0, 4'd5, 64'h55); sample();
        total++;
        if (cache_wr_en !== 1'b1 || cache_wr_pc !== 64'h100 || cache_wr_data !== 64'h33) begin
            bad++;
            $display("FAIL tag3_line: en=%b pc=%h data=%h want 1/100/33", cache_wr_en, cache_wr_pc, cache_wr_data);
        end
        next();
        set_in(0, 64'd0, 0, 0, 0, 0, 64'd0); sample();
        total++;
        if (cache_wr_en !== 1'b1 || cache_wr_pc !== 64'h110 || cache_wr_data !== 64'h55) begin
            bad++;
            $display("FAIL tag5_line: en=%b pc=%h data=%h want 1/110/55", cache_wr_en, cache_wr_pc, cache_wr_data);
        end
        next();
    endtask

    task automatic test_refill();
        logic [1:0]  ec [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
        logic [63:0] ea [4] = '{64'h108, 64'h0, 64'h118, 64'h0};
        logic [3:0]  rs [4] = '{4'd6, 4'd7, 4'd8, 4'd0};
        do_reset();
        burst(64'h100, 4'd3, 4'd4, 4'd5);
        set_in(0, 64'd0, 0, 0, 0, 4'd4, 64'hDEAD); sample();
        total++;
        if (cache_wr_en !== 1'b0) begin bad++; $display("FAIL refill_early: en=%b want 0", cache_wr_en); end
        next();
        set_in(0, 64'd0, 0, 0, 0, 4'd9, 64'hBEEF); sample();
        total++;
        if (cache_wr_en !== 1'b1 || cache_wr_pc !== 64'h108 || cache_wr_data !== 64'hDEAD) begin
            bad++;
            $display("FAIL refill_tag4: en=%b pc=%h data=%h want 1/108/dead", cache_wr_en, cache_wr_pc, cache_wr_data);
        end
        next();
        set_in(0, 64'd0, 0, 0, 0, 0, 64'd0); sample();
        total++;
        if (cache_wr_en !== 1'b0) begin bad++; $display("FAIL unknown_tag9: en=%b want 0", cache_wr_en); end
        next();
        set_in(1, 64'h108, 0, 1, 0, 0, 64'd0); sample(); next();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 64'd0, 0, 1, rs[i], 0, 64'd0);
            sample();
            total++;
            if (proc2mem_command !== ec[i] || proc2mem_addr !== ea[i]) begin
                bad++;
                $display("FAIL reload_skip[%0d]: cmd=%0d addr=%h want cmd=%0d addr=%h",
                         i, proc2mem_command, proc2mem_addr, ec[i], ea[i]);
            end
            next();
        end
    endtask

    task automatic test_stall();
        bit          gn [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  rs [6] = '{4'd7, 4'd7, 4'd7, 4'd0, 4'd7, 4'd0};
        logic [63:0] ea [6] = '{64'h200, 64'h200, 64'h200, 64'h200, 64'h200, 64'h208};
        do_reset();
        set_in(1, 64'h200, 0, 0, 0, 0, 64'd0); sample(); next();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 64'd0, 0, gn[i], rs[i], 0, 64'd0);
            sample();
            total++;
            if (proc2mem_command !== 2'd1 || proc2mem_addr !== ea[i]) begin
                bad++;
                $display("FAIL stall[%0d]: cmd=%0d addr=%h want cmd=1 addr=%h", i, proc2mem_command, proc2mem_addr, ea[i]);
            end
            next();
        end
        set_in(0, 64'd0, 0, 0, 0, 4'd7, 64'h77); sample(); next();
        set_in(0, 64'd0, 0, 0, 0, 0, 64'd0); sample();
        total++;
        if (cache_wr_en !== 1'b1 || cache_wr_pc !== 64'h200) begin
            bad++;
            $display("FAIL stall_tag7: en=%b pc=%h want 1/200", cache_wr_en, cache_wr_pc);
        end
        next();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        burst(64'h100, 4'd3, 4'd4, 4'd5);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 64'd0, 0, 0, 0, 4'(3 + i), 64'h99);
            sample();
            total++;
            if (cache_wr_en !== 1'b0 || proc2mem_command !== 2'd0) begin
                bad++;
                $display("FAIL stale_tag[%0d]: en=%b cmd=%0d want 0/0", i, cache_wr_en, proc2mem_command);
            end
            next();
        end
    endtask

    task automatic test_full();
        logic [1:0]  ec [9] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        logic [63:0] ea [9] = '{64'h0, 64'h300, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h500};
        logic [63:0] pc [9] = '{64'h300, 64'h0, 64'h0, 64'h500, 64'h500, 64'h500, 64'h500, 64'h500, 64'h500};
        logic [3:0]  rs [9] = '{4'd0, 4'd4, 4'd9, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        do_reset();
        burst(64'h100, 4'd1, 4'd2, 4'd3);
        for (int i = 0; i < 9; i++) begin
            set_in(pc[i] != 64'd0, pc[i], 0, 1, rs[i], (i == 7) ? 4'd2 : 4'd0, 64'h22);
            sample();
            total++;
            if (proc2mem_command !== ec[i] || proc2mem_addr !== ea[i]) begin
                bad++;
                $display("FAIL full[%0d]: cmd=%0d addr=%h want cmd=%0d addr=%h",
                         i, proc2mem_command, proc2mem_addr, ec[i], ea[i]);
            end
            if (i == 8) begin
                total++;
                if (cache_wr_en !== 1'b1 || cache_wr_pc !== 64'h108) begin
                    bad++;
                    $display("FAIL full_free: en=%b pc=%h want 1/108", cache_wr_en, cache_wr_pc);
                end
            end
            next();
        end
    endtask

    task automatic test_abandon();
        logic [63:0] pc [11] = '{64'h100, 64'h0, 64'h400, 64'h400, 64'h400, 64'h100, 64'h100,
                                 64'h100, 64'h100, 64'h100, 64'h100};
        logic [3:0]  rs [11] = '{4'd0, 4'd3, 4'd4, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8};
        logic [1:0]  ec [11] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [63:0] ea [11] = '{64'h0, 64'h100, 64'h108, 64'h0, 64'h400, 64'h408, 64'h0,
                                 64'h0, 64'h0, 64'h0, 64'h0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            set_in(pc[i] != 64'd0, pc[i], 0, 1, rs[i], (i == 6) ? 4'd5 : 4'd0, 64'd0);
            sample();
            total++;
            if (proc2mem_command !== ec[i] || proc2mem_addr !== ea[i]) begin
                bad++;
                $display("FAIL abandon[%0d]: cmd=%0d addr=%h want cmd=%0d addr=%h",
                         i, proc2mem_command, proc2mem_addr, ec[i], ea[i]);
            end
            next();
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  rs [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        logic [1:0]  ec [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        logic [63:0] ea [4] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8, 64'h0};
        do_reset();
        set_in(1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1, 0, 0, 64'd0); sample(); next();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 64'd0, 0, 1, rs[i], 0, 64'd0);
            sample();
            total++;
            if (proc2mem_command !== ec[i] || proc2mem_addr !== ea[i]) begin
                bad++;
                $display("FAIL wrap[%0d]: cmd=%0d addr=%h want cmd=%0d addr=%h",
                         i, proc2mem_command, proc2mem_addr, ec[i], ea[i]);
            end
            next();
        end
    endtask

    task automatic test_random();
        logic [3:0] tg, rsp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(1) == 0 && m_tbl.size() != 0)
                tg = m_tbl[$urandom_range(m_tbl.size() - 1)].tag;
            else if ($urandom_range(2) == 0) tg = 4'($urandom_range(15));
            else tg = 4'd0;
            rsp = 4'd0;
            if ($urandom_range(3) != 0) begin
                for (int a = 0; a < 20; a++) begin
                    rsp = 4'($urandom_range(15, 1));
                    if (!tag_in_tbl(rsp) || rsp == tg) break;
                end
                if (tag_in_tbl(rsp) && rsp != tg) rsp = 4'd0;
            end
            set_in($urandom_range(9) < 7, 64'h1000 + 64'(8 * $urandom_range(11)) + 64'($urandom_range(7)),
                   $urandom_range(1) == 1, $urandom_range(9) < 6, rsp, tg, {$urandom, $urandom});
            cache_rd_data = {$urandom, $urandom};
            sample();
            total++;
            if (proc2mem_command !== e_cmd || proc2mem_addr !== e_addr) begin
                bad++;
                $display("FAIL rnd_bus[%0d]: cmd=%0d addr=%h want cmd=%0d addr=%h",
                         n, proc2mem_command, proc2mem_addr, e_cmd, e_addr);
            end
            total++;
            if (if_valid !== e_ifv || if_data !== cache_rd_data || cache_rd_pc !== if_pc) begin
                bad++;
                $display("FAIL rnd_hit[%0d]: valid=%b data=%h rd_pc=%h want %b/%h/%h",
                         n, if_valid, if_data, cache_rd_pc, e_ifv, cache_rd_data, if_pc);
            end
            total++;
            if (cache_wr_en !== e_wr_en || (e_wr_en && (cache_wr_pc !== e_wr_pc || cache_wr_data !== e_wr_data))) begin
                bad++;
                $display("FAIL rnd_refill[%0d]: en=%b pc=%h data=%h want %b/%h/%h",
                         n, cache_wr_en, cache_wr_pc, cache_wr_data, e_wr_en, e_wr_pc, e_wr_data);
            end
            next();
        end
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_prefetch_burst();
        test_refill();
        test_stall();
        test_reset_midflight();
        test_full();
        test_abandon();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
